// File: rtl/tty_tx_pkg.sv
// Shared constants for the console teleprinter: major-state code, IOT opcodes,
// and the shifter state encoding.
package tty_tx_pkg;

  // Major-state code for the execute phase in which IOTs are decoded
  localparam logic [4:0] F3 = 5'd3;

  // Teleprinter IOT group plus the keyboard-interrupt-enable shared decode
  localparam logic [11:0] IOT_TFL = 12'o6040;
  localparam logic [11:0] IOT_TSF = 12'o6041;
  localparam logic [11:0] IOT_TCF = 12'o6042;
  localparam logic [11:0] IOT_TPC = 12'o6044;
  localparam logic [11:0] IOT_TSK = 12'o6045;
  localparam logic [11:0] IOT_TLS = 12'o6046;
  localparam logic [11:0] IOT_KIE = 12'o6035;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tty_tx_baud.sv
// Divide-by-DIV bit-period counter. Counts 0..DIV-1 and wraps; tick_o is high
// for the single cycle the count sits at DIV-1. restart_i pins it to 0.
module tty_baud #(
  parameter int DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  // Free-running period counter with synchronous restart
  always_ff @(posedge clk_i) begin
    if (!rst_ni || restart_i) cnt_q <= '0;
    else if (cnt_q == LAST)   cnt_q <= '0;
    else                      cnt_q <= cnt_q + W'(1);
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/tty_tx.sv
// PDP-8/e console teleprinter transmitter: decodes the 604x IOT group in F3,
// serializes ac[4:11] as an 8N1/8N2 frame on tx, and keeps the printer flag.
module tty_tx
  import tty_tx_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int STOP_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [4:0]  state,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  input  logic        UF,
  input  logic        kbd_flag,
  output logic        tx,
  output logic        skip,
  output logic        flag,
  output logic        irq,
  output logic        busy
);

  localparam int DIV = CLOCK_FREQ / BAUD;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_e  st_q;
  logic [7:0] sh_q, hold_q;
  logic       hold_v_q;
  logic [2:0] bit_q;
  logic       tx_q, flag_q, ie_q, skip_q;

  logic       iot, op_load, op_clr_flag, op_set_flag, op_kie, skip_d;
  logic       tick, restart, frame_end, direct;
  logic [7:0] ch;
  logic       unused_ac;

  assign ch        = ac[4:11];      // ch[0] = ac[11], sent first
  assign unused_ac = ^ac[0:3];

  // IOT decode, qualified by F3 and supervisor mode
  always_comb begin
    iot         = (state == F3) && !UF;
    op_load     = 1'b0;
    op_clr_flag = 1'b0;
    op_set_flag = 1'b0;
    op_kie      = 1'b0;
    skip_d      = 1'b0;
    if (iot) begin
      op_load     = (instruction == IOT_TPC) || (instruction == IOT_TLS);
      op_clr_flag = (instruction == IOT_TCF) || (instruction == IOT_TLS);
      op_set_flag = (instruction == IOT_TFL);
      op_kie      = (instruction == IOT_KIE);
      skip_d      = ((instruction == IOT_TSF) && flag_q) ||
                    ((instruction == IOT_TSK) && (flag_q || kbd_flag));
    end
  end

  assign frame_end = (st_q == STOP) && tick && (bit_q == LAST_STOP);
  // A load goes straight into the shifter when nothing else will occupy it
  assign direct    = (st_q == IDLE) || (frame_end && !hold_v_q);
  // Only an idle start needs a restart; chained frames start on a wrap
  assign restart   = clear || ((st_q == IDLE) && op_load);

  tty_baud #(.DIV(DIV)) u_baud (
    .clk_i     (clk),
    .rst_ni    (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Shifter FSM, holding register, printer flag, interrupt enable and skip
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      st_q     <= IDLE;
      tx_q     <= 1'b1;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      bit_q    <= '0;
      flag_q   <= 1'b0;
      ie_q     <= 1'b1;
      skip_q   <= 1'b0;
    end else begin
      skip_q <= skip_d;
      if (op_kie) ie_q <= ac[11];
      // TCF/TLS beat a frame completing in the same cycle
      if (op_clr_flag)                   flag_q <= 1'b0;
      else if (op_set_flag || frame_end) flag_q <= 1'b1;

      case (st_q)
        IDLE: if (op_load) begin
          sh_q <= ch;
          tx_q <= 1'b0;
          st_q <= START;
        end
        START: if (tick) begin
          tx_q  <= sh_q[0];
          sh_q  <= {1'b0, sh_q[7:1]};
          bit_q <= '0;
          st_q  <= DATA;
        end
        DATA: if (tick) begin
          if (bit_q == 3'd7) begin
            tx_q  <= 1'b1;
            bit_q <= '0;
            st_q  <= STOP;
          end else begin
            tx_q  <= sh_q[0];
            sh_q  <= {1'b0, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
          end
        end
        STOP: if (tick) begin
          if (bit_q == LAST_STOP) begin
            if (hold_v_q) begin
              sh_q <= hold_q;
              tx_q <= 1'b0;
              st_q <= START;
            end else if (op_load) begin
              sh_q <= ch;
              tx_q <= 1'b0;
              st_q <= START;
            end else begin
              st_q <= IDLE;
            end
          end else begin
            bit_q <= bit_q + 3'd1;
          end
        end
        default: st_q <= IDLE;
      endcase

      // Last writer wins; a pop and a new load in one cycle keep it full
      if (op_load && !direct) begin
        hold_q   <= ch;
        hold_v_q <= 1'b1;
      end else if (frame_end && hold_v_q) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  assign tx   = tx_q;
  assign skip = skip_q;
  assign flag = flag_q;
  assign irq  = flag_q & ie_q;
  assign busy = (st_q != IDLE) || hold_v_q;

endmodule

// File: tb/tb_tty_tx.sv
// Self-checking bench for tty_tx at DIV=16, two stop bits: directed table,
// hand-written frame sequences, and random IOT traffic against a frame-timeline model.
module tb_tty_tx;
  import tty_tx_pkg::*;

  localparam int DIV = 16;
  localparam int SB  = 2;
  localparam int FL  = (9 + SB) * DIV;
  localparam logic [11:0] NOP = 12'o0000;

  logic        clk = 1'b0;
  logic        reset, clear, UF, kbd_flag;
  logic [4:0]  state;
  logic [0:11] instruction, ac;
  logic        tx, skip, flag, irq, busy;

  tty_tx #(.CLOCK_FREQ(16), .BAUD(1), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .clear(clear), .state(state),
    .instruction(instruction), .ac(ac), .UF(UF), .kbd_flag(kbd_flag),
    .tx(tx), .skip(skip), .flag(flag), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a frame is just (start cycle, character); tx is derived
  // from elapsed time since the start.
  bit         m_act, m_hold_v, m_flag, m_ie, m_skip;
  logic [7:0] m_char, m_hold;
  int         m_start;

  function automatic logic m_tx();
    int e, b;
    if (!m_act) return 1'b1;
    e = cyc - m_start;
    b = e / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_char[b-1];
    return 1'b1;
  endfunction

  task automatic model_step();
    bit io, fe, ld;
    logic [11:0] op;
    cyc++;
    if (!reset || clear) begin
      m_act = 0; m_hold_v = 0; m_flag = 0; m_ie = 1; m_skip = 0;
    end else begin
      io = (state == F3) && !UF;
      op = instruction;
      fe = m_act && (cyc - m_start == FL);
      m_skip = io && ((op == IOT_TSF && m_flag) || (op == IOT_TSK && (m_flag || kbd_flag)));
      if (fe) begin
        m_act = 0;
        if (m_hold_v) begin m_act = 1; m_start = cyc; m_char = m_hold; m_hold_v = 0; end
      end
      ld = io && (op == IOT_TPC || op == IOT_TLS);
      if (ld) begin
        if (!m_act) begin m_act = 1; m_start = cyc; m_char = ac[4:11]; end
        else begin m_hold = ac[4:11]; m_hold_v = 1; end
      end
      if (io && (op == IOT_TCF || op == IOT_TLS)) m_flag = 0;
      else if ((io && op == IOT_TFL) || fe)      m_flag = 1;
      if (io && op == IOT_KIE) m_ie = ac[11];
    end
  endtask

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: tx/busy/flag/irq/skip got %b expected %b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] outs();
    return {tx, busy, flag, irq, skip};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", outs(), {m_tx(), m_act || m_hold_v, m_flag, m_flag && m_ie, m_skip});
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic set_idle();
    state = 5'd0; instruction = NOP; ac = '0; UF = 0; kbd_flag = 0; clear = 0;
  endtask

  task automatic iot(input logic [11:0] op, input logic [11:0] a, input bit uf, input bit kbd);
    state = F3; instruction = op; ac = a; UF = uf; kbd_flag = kbd;
    tick();
    set_idle();
  endtask

  // Sample tx and busy mid-bit for each bit not yet passed, then run to frame end.
  task automatic frame_chk(input string nm, input logic [0:10] pat, input int e0);
    int e, t;
    e = e0;
    for (int b = 0; b < 11; b++) begin
      t = b * DIV + DIV / 2;
      if (t >= e) begin
        run(t - e);
        e = t;
        chk($sformatf("%s_bit%0d", nm, b), {tx, busy, 3'b000}, {pat[b], 1'b1, 3'b000});
      end
    end
    run(FL - e);
  endtask

  typedef struct {
    logic [11:0] op;
    logic [11:0] a;
    bit          uf;
    bit          kbd;
    int          wt;
    logic [4:0]  exp;  // tx, busy, flag, irq, skip
  } vec_t;

  vec_t tbl[$];
  logic [11:0] ops[9] = '{IOT_TFL, IOT_TSF, IOT_TCF, IOT_TPC, IOT_TSK,
                          IOT_TLS, IOT_KIE, 12'o6043, 12'o6047};

  initial begin
    set_idle();
    reset = 0;
    run(3);
    reset = 1;
    chk("reset", outs(), 5'b10000);

    tbl.push_back('{IOT_TSF, 12'o0000, 0, 0, 0,   5'b10000}); // skip stays low after reset
    tbl.push_back('{IOT_TLS, 12'o0101, 0, 0, 0,   5'b01000}); // start bit next cycle
    tbl.push_back('{NOP,     12'o0000, 0, 0, 175, 5'b11000}); // last stop bit
    tbl.push_back('{NOP,     12'o0000, 0, 0, 1,   5'b10110}); // flag at 176
    tbl.push_back('{IOT_TSF, 12'o0000, 0, 0, 0,   5'b10111});
    tbl.push_back('{NOP,     12'o0000, 0, 0, 1,   5'b10110}); // one-cycle skip
    tbl.push_back('{IOT_TCF, 12'o0000, 0, 0, 0,   5'b10000});
    tbl.push_back('{IOT_TSK, 12'o0000, 0, 1, 0,   5'b10001}); // keyboard flag skip
    tbl.push_back('{IOT_TSK, 12'o0000, 0, 0, 0,   5'b10000});
    tbl.push_back('{IOT_TLS, 12'o0101, 1, 0, 0,   5'b10000}); // user mode inhibits
    tbl.push_back('{IOT_TFL, 12'o0000, 1, 0, 0,   5'b10000});
    tbl.push_back('{NOP,     12'o0000, 0, 0, 20,  5'b10000});
    tbl.push_back('{IOT_TFL, 12'o0000, 0, 0, 0,   5'b10110});
    tbl.push_back('{IOT_KIE, 12'o0000, 0, 0, 0,   5'b10100}); // ie off masks irq
    tbl.push_back('{IOT_TLS, 12'o0101, 0, 0, 0,   5'b01000});
    tbl.push_back('{NOP,     12'o0000, 0, 0, 176, 5'b10100}); // flag=1, irq=0
    tbl.push_back('{IOT_KIE, 12'o0001, 0, 0, 0,   5'b10110});
    tbl.push_back('{IOT_TCF, 12'o0000, 0, 0, 0,   5'b10000});
    tbl.push_back('{IOT_TPC, 12'o0377, 0, 0, 0,   5'b01000});
    tbl.push_back('{NOP,     12'o0000, 0, 0, 175, 5'b11000});
    tbl.push_back('{IOT_TCF, 12'o0000, 0, 0, 0,   5'b10000}); // TCF beats frame end
    tbl.push_back('{NOP,     12'o0000, 0, 0, 5,   5'b10000});
    tbl.push_back('{12'o6043,12'o0000, 0, 0, 0,   5'b10000}); // unused code ignored
    tbl.push_back('{IOT_TFL, 12'o0000, 0, 0, 0,   5'b10110});
    tbl.push_back('{12'o6047,12'o0377, 0, 0, 0,   5'b10110});

    foreach (tbl[i]) begin
      if (tbl[i].op != NOP) iot(tbl[i].op, tbl[i].a, tbl[i].uf, tbl[i].kbd);
      run(tbl[i].wt);
      chk($sformatf("tbl%0d", i), outs(), tbl[i].exp);
    end

    // Single TLS: bit-by-bit frame, then flag/irq and TSF skip
    iot(IOT_TLS, 12'o0101, 0, 0);
    frame_chk("tls", 11'b01000001011, 0);
    chk("tls_end", outs(), 5'b10110);
    iot(IOT_TSF, 12'o0000, 0, 0);
    chk("tls_tsf", outs(), 5'b10111);
    tick();
    chk("tls_tsf_drop", outs(), 5'b10110);

    // Holding register: back-to-back frames, last writer wins
    iot(IOT_TCF, 12'o0000, 0, 0);
    iot(IOT_TPC, 12'o0123, 0, 0);
    run(19);
    iot(IOT_TPC, 12'o0177, 0, 0);
    run(19);
    iot(IOT_TPC, 12'o0055, 0, 0);
    frame_chk("hold1", 11'b01100101011, 40);
    chk("hold_gap", {tx, busy, flag, 2'b00}, 5'b01100);
    frame_chk("hold2", 11'b01011010011, 0);
    chk("hold_done", {tx, busy, 3'b000}, 5'b10000);
    run(40);
    chk("hold_no_third", {tx, busy, 3'b000}, 5'b10000);

    // Clear during data bit 3 with the holding register full and ie off
    iot(IOT_KIE, 12'o0000, 0, 0);
    iot(IOT_TLS, 12'o0000, 0, 0);
    run(9);
    iot(IOT_TPC, 12'o0101, 0, 0);
    run(59);
    chk("clr_pre", {tx, busy, 3'b000}, 5'b01000);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_now", outs(), 5'b10000);
    iot(IOT_TFL, 12'o0000, 0, 0);
    chk("clr_ie", outs(), 5'b10110);
    run(200);
    chk("clr_idle", {tx, busy, 3'b000}, 5'b10000);

    // Random IOT traffic against the model
    for (int i = 0; i < 6000; i++) begin
      state       = ($urandom_range(0, 4) == 0) ? F3 : 5'($urandom_range(0, 31));
      instruction = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 8)] : 12'($urandom);
      ac          = 12'($urandom);
      UF          = ($urandom_range(0, 9) == 0);
      kbd_flag    = 1'($urandom);
      clear       = ($urandom_range(0, 399) == 0);
      reset       = ($urandom_range(0, 699) != 0);
      tick();
    end
    set_idle();
    reset = 1;
    run(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
